// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: FETCH -> DECODE -> EXE -> MEM -> WB sequencer.
// Define MC_CTRL_RETIRE_CNT_EN to add the retired-instruction counter output.
module mips_mc_ctrl #(
    parameter int LINK_REG = 31,
    parameter int CNT_W    = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] state,
    output logic       ir_wr,
    output logic       pc_wr,
    output logic [1:0] npc_sel,
    output logic       reg_wr,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       alu_src,
    output logic       ext_op,
    output logic [1:0] alu_op,
    output logic       mem_req,
    output logic       mem_wr
`ifdef MC_CTRL_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retire_cnt
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXE    = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_OR  = 2'd2;
    localparam logic [1:0] ALU_LUI = 2'd3;

    // reg_dst=2 selects LINK_REG inside the datapath; the range must fit the GRF
    if (CNT_W < 1 || LINK_REG < 0 || LINK_REG > 31) begin : g_param_chk
        $error("mips_mc_ctrl: bad CNT_W or LINK_REG");
    end

    state_t state_r, state_nxt;

    logic is_r, is_addu, is_subu, is_jr, is_j, is_jal;
    logic is_beq, is_ori, is_lui, is_lw, is_sw;

    always_comb begin
        is_r    = (opcode == OP_R);
        is_addu = is_r && (funct == FN_ADDU);
        is_subu = is_r && (funct == FN_SUBU);
        is_jr   = is_r && (funct == FN_JR);
        is_j    = (opcode == OP_J);
        is_jal  = (opcode == OP_JAL);
        is_beq  = (opcode == OP_BEQ);
        is_ori  = (opcode == OP_ORI);
        is_lui  = (opcode == OP_LUI);
        is_lw   = (opcode == OP_LW);
        is_sw   = (opcode == OP_SW);
    end

    always_ff @(posedge clk) begin
        if (reset) state_r <= FETCH;
        else       state_r <= state_nxt;
    end

    assign state = state_r;

    always_comb begin
        state_nxt = state_r;
        ir_wr     = 1'b0;
        pc_wr     = 1'b0;
        npc_sel   = 2'd0;
        reg_wr    = 1'b0;
        reg_dst   = 2'd0;
        wd_sel    = 2'd0;
        alu_src   = 1'b0;
        ext_op    = 1'b0;
        alu_op    = ALU_ADD;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;

        case (state_r)
            FETCH: begin
                ir_wr     = 1'b1;
                pc_wr     = 1'b1;
                state_nxt = DECODE;
            end
            DECODE: begin
                state_nxt = FETCH;
                if (is_j) begin
                    pc_wr   = 1'b1;
                    npc_sel = 2'd2;
                end else if (is_jal) begin
                    // GRF captures PC+4 on the same edge that redirects the PC
                    pc_wr   = 1'b1;
                    npc_sel = 2'd2;
                    reg_wr  = 1'b1;
                    reg_dst = 2'd2;
                    wd_sel  = 2'd2;
                end else if (is_jr) begin
                    pc_wr   = 1'b1;
                    npc_sel = 2'd3;
                end else if (is_addu || is_subu || is_ori || is_lui ||
                             is_lw || is_sw || is_beq) begin
                    state_nxt = EXE;
                end
            end
            EXE: begin
                state_nxt = WB;
                if (is_subu) begin
                    alu_op = ALU_SUB;
                end else if (is_ori) begin
                    alu_src = 1'b1;
                    alu_op  = ALU_OR;
                end else if (is_lui) begin
                    alu_src = 1'b1;
                    alu_op  = ALU_LUI;
                end else if (is_lw || is_sw) begin
                    alu_src   = 1'b1;
                    ext_op    = 1'b1;
                    state_nxt = MEM;
                end else if (is_beq) begin
                    alu_op    = ALU_SUB;
                    npc_sel   = 2'd1;
                    pc_wr     = zero;
                    state_nxt = FETCH;
                end
            end
            MEM: begin
                // address selects stay as in EXE so the ALU output holds
                alu_src = 1'b1;
                ext_op  = 1'b1;
                mem_req = 1'b1;
                mem_wr  = is_sw;
                if (mem_ready) state_nxt = is_sw ? FETCH : WB;
            end
            WB: begin
                reg_wr    = 1'b1;
                reg_dst   = is_r ? 2'd1 : 2'd0;
                wd_sel    = is_lw ? 2'd1 : 2'd0;
                state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase

        if (reset) begin
            state_nxt = FETCH;
            ir_wr     = 1'b0;
            pc_wr     = 1'b0;
            npc_sel   = 2'd0;
            reg_wr    = 1'b0;
            reg_dst   = 2'd0;
            wd_sel    = 2'd0;
            alu_src   = 1'b0;
            ext_op    = 1'b0;
            alu_op    = ALU_ADD;
            mem_req   = 1'b0;
            mem_wr    = 1'b0;
        end
    end

`ifdef MC_CTRL_RETIRE_CNT_EN
    logic retire;
    assign retire = (state_nxt == FETCH) &&
                    (state_r == DECODE || state_r == EXE ||
                     state_r == MEM || state_r == WB);

    always_ff @(posedge clk) begin
        if (reset)       retire_cnt <= '0;
        else if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: walks each instruction class cycle by cycle.
module tb_mips_mc_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic [2:0] state;
    logic       ir_wr, pc_wr, reg_wr, alu_src, ext_op, mem_req, mem_wr;
    logic [1:0] npc_sel, reg_dst, wd_sel, alu_op;
`ifdef MC_CTRL_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
    logic [31:0] cnt0;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mips_mc_ctrl #(.LINK_REG(31), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .state(state),
        .ir_wr(ir_wr), .pc_wr(pc_wr), .npc_sel(npc_sel), .reg_wr(reg_wr),
        .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src(alu_src),
        .ext_op(ext_op), .alu_op(alu_op), .mem_req(mem_req), .mem_wr(mem_wr)
`ifdef MC_CTRL_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; opcode = 6'b100011; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        next_cycle(); next_cycle();
        n_chk++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state); end
        n_chk++; if ({ir_wr, pc_wr, reg_wr, mem_req, mem_wr} !== 5'b0) begin n_fail++;
            $display("FAIL reset_enables got %b exp 00000", {ir_wr, pc_wr, reg_wr, mem_req, mem_wr}); end
`ifdef MC_CTRL_RETIRE_CNT_EN
        n_chk++; if (retire_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", retire_cnt); end
`endif
        reset = 1'b0;
        next_cycle(); next_cycle(); next_cycle();
        #1;
        n_chk++; if (state !== 3'd3 || mem_req !== 1'b1) begin n_fail++;
            $display("FAIL reset_pre_mem got st=%0d req=%b exp st=3 req=1", state, mem_req); end
        reset = 1'b1;
        #1;
        n_chk++; if ({mem_req, mem_wr, ir_wr, pc_wr, reg_wr} !== 5'b0 ||
                     {npc_sel, reg_dst, wd_sel, alu_op, alu_src, ext_op} !== 10'b0) begin n_fail++;
            $display("FAIL reset_mid_mem got req=%b sel=%b exp all zero", mem_req,
                     {npc_sel, reg_dst, wd_sel, alu_op, alu_src, ext_op}); end
        next_cycle();
        n_chk++; if (state !== 3'd0 || ir_wr !== 1'b0 || pc_wr !== 1'b0) begin n_fail++;
            $display("FAIL reset_held got st=%0d ir=%b pc=%b exp 0 0 0", state, ir_wr, pc_wr); end
        next_cycle();
        reset = 1'b0;
        #1;
        n_chk++; if (state !== 3'd0 || ir_wr !== 1'b1 || pc_wr !== 1'b1 || npc_sel !== 2'd0) begin n_fail++;
            $display("FAIL reset_release got st=%0d ir=%b pc=%b ns=%0d exp 0 1 1 0", state, ir_wr, pc_wr, npc_sel); end
    endtask

    task automatic test_addu();
        logic [2:0] exp_st [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
`ifdef MC_CTRL_RETIRE_CNT_EN
        cnt0 = retire_cnt;
`endif
        opcode = 6'b000000; funct = 6'b100001;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_chk++; if (state !== exp_st[i] || reg_wr !== (i == 3)) begin n_fail++;
                $display("FAIL addu_cyc%0d got st=%0d rw=%b exp st=%0d rw=%b", i, state, reg_wr, exp_st[i], i == 3); end
            if (i == 2) begin
                n_chk++; if (alu_src !== 1'b0 || alu_op !== 2'd0) begin n_fail++;
                    $display("FAIL addu_exe got src=%b op=%0d exp 0 0", alu_src, alu_op); end
            end
            if (i == 3) begin
                n_chk++; if (reg_dst !== 2'd1 || wd_sel !== 2'd0) begin n_fail++;
                    $display("FAIL addu_wb got dst=%0d wd=%0d exp 1 0", reg_dst, wd_sel); end
            end
            if (i < 4) next_cycle();
        end
`ifdef MC_CTRL_RETIRE_CNT_EN
        n_chk++; if (retire_cnt !== cnt0 + 32'd1) begin n_fail++;
            $display("FAIL addu_cnt got %0d exp %0d", retire_cnt, cnt0 + 32'd1); end
`endif
    endtask

    task automatic test_ori();
        opcode = 6'b001101; funct = 6'b100011;
        next_cycle(); next_cycle(); #1;
        n_chk++; if (state !== 3'd2 || alu_src !== 1'b1 || ext_op !== 1'b0 || alu_op !== 2'd2) begin n_fail++;
            $display("FAIL ori_exe got st=%0d src=%b ext=%b op=%0d exp 2 1 0 2", state, alu_src, ext_op, alu_op); end
        next_cycle(); #1;
        n_chk++; if (state !== 3'd4 || reg_wr !== 1'b1 || reg_dst !== 2'd0 || wd_sel !== 2'd0) begin n_fail++;
            $display("FAIL ori_wb got st=%0d rw=%b dst=%0d wd=%0d exp 4 1 0 0", state, reg_wr, reg_dst, wd_sel); end
        next_cycle();
    endtask

    task automatic test_lw_wait();
        logic [2:0] exp_st [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        opcode = 6'b100011; funct = 6'd0;
        for (int i = 0; i < 8; i++) begin
            mem_ready = (i == 6);
            #1;
            n_chk++; if (state !== exp_st[i] || mem_req !== (exp_st[i] == 3'd3) || mem_wr !== 1'b0) begin n_fail++;
                $display("FAIL lw_cyc%0d got st=%0d req=%b wr=%b exp st=%0d req=%b wr=0",
                         i, state, mem_req, mem_wr, exp_st[i], exp_st[i] == 3'd3); end
            if (i == 7) begin
                n_chk++; if (reg_wr !== 1'b1 || wd_sel !== 2'd1 || reg_dst !== 2'd0) begin n_fail++;
                    $display("FAIL lw_wb got rw=%b wd=%0d dst=%0d exp 1 1 0", reg_wr, wd_sel, reg_dst); end
            end
            next_cycle();
        end
        mem_ready = 1'b0;
        n_chk++; if (state !== 3'd0) begin n_fail++; $display("FAIL lw_end got st=%0d exp 0", state); end
    endtask

    task automatic test_beq();
        logic zv [2] = '{1'b1, 1'b0};
        opcode = 6'b000100; funct = 6'd0;
        for (int k = 0; k < 2; k++) begin
            zero = zv[k];
            next_cycle(); next_cycle(); #1;
            n_chk++; if (state !== 3'd2 || pc_wr !== zv[k] || npc_sel !== 2'd1 || alu_op !== 2'd1) begin n_fail++;
                $display("FAIL beq_z%0d got st=%0d pcw=%b ns=%0d op=%0d exp 2 %b 1 1",
                         zv[k], state, pc_wr, npc_sel, alu_op, zv[k]); end
            next_cycle();
            n_chk++; if (state !== 3'd0) begin n_fail++; $display("FAIL beq_ret_z%0d got st=%0d exp 0", zv[k], state); end
        end
        zero = 1'b0;
    endtask

    task automatic test_jumps();
        opcode = 6'b000011; funct = 6'd0;
        next_cycle(); #1;
        n_chk++; if (state !== 3'd1 || pc_wr !== 1'b1 || npc_sel !== 2'd2 || reg_wr !== 1'b1 ||
                     reg_dst !== 2'd2 || wd_sel !== 2'd2) begin n_fail++;
            $display("FAIL jal_dec got st=%0d pcw=%b ns=%0d rw=%b dst=%0d wd=%0d exp 1 1 2 1 2 2",
                     state, pc_wr, npc_sel, reg_wr, reg_dst, wd_sel); end
        next_cycle();
        n_chk++; if (state !== 3'd0) begin n_fail++; $display("FAIL jal_ret got st=%0d exp 0", state); end
        opcode = 6'b000000; funct = 6'b001000;
        next_cycle(); #1;
        n_chk++; if (pc_wr !== 1'b1 || npc_sel !== 2'd3 || reg_wr !== 1'b0) begin n_fail++;
            $display("FAIL jr_dec got pcw=%b ns=%0d rw=%b exp 1 3 0", pc_wr, npc_sel, reg_wr); end
        next_cycle();
        n_chk++; if (state !== 3'd0) begin n_fail++; $display("FAIL jr_ret got st=%0d exp 0", state); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_st [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
`ifdef MC_CTRL_RETIRE_CNT_EN
        cnt0 = retire_cnt;
`endif
        opcode = 6'b111111; funct = 6'd0;
        next_cycle(); #1;
        n_chk++; if (state !== 3'd1 || {ir_wr, pc_wr, reg_wr, mem_req, mem_wr} !== 5'b0) begin n_fail++;
            $display("FAIL unk_dec got st=%0d en=%b exp 1 00000", state, {ir_wr, pc_wr, reg_wr, mem_req, mem_wr}); end
        next_cycle();
        opcode = 6'b101011; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++; if (state !== exp_st[i] || mem_wr !== (i == 3) || reg_wr !== 1'b0) begin n_fail++;
                $display("FAIL sw_cyc%0d got st=%0d wr=%b rw=%b exp st=%0d wr=%b rw=0",
                         i, state, mem_wr, reg_wr, exp_st[i], i == 3); end
            next_cycle();
        end
        mem_ready = 1'b0;
        n_chk++; if (state !== 3'd0) begin n_fail++; $display("FAIL sw_end got st=%0d exp 0", state); end
`ifdef MC_CTRL_RETIRE_CNT_EN
        n_chk++; if (retire_cnt !== cnt0 + 32'd2) begin n_fail++;
            $display("FAIL b2b_cnt got %0d exp %0d", retire_cnt, cnt0 + 32'd2); end
`endif
    endtask

    initial begin
        test_reset();
        test_addu();
        test_ori();
        test_lw_wait();
        test_beq();
        test_jumps();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
